barrido_tabla_verdad: RTL and testbench

Stimulus-side counterpart of the 5-input sum-of-products function blocks. It drives X,Y,Z,K,M through all 32 input combinations and waits a programmable settle time per vector. It samples the returned function output F into a 32-bit truth table, counts minterms and compares against an expected table. It sits between a lab controller (start/done) and any 5-input combinational function under test.

---
 rtl/barrido_tabla_verdad_pkg.sv | 31 +++
 rtl/barrido_tabla_verdad_if.sv | 37 +++
 rtl/barrido_tabla_verdad_settle_timer.sv | 43 ++++
 rtl/barrido_tabla_verdad.sv | 136 +++++++++++++
 tb/tb_barrido_tabla_verdad.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/barrido_tabla_verdad_pkg.sv
// Shared definitions for the truth-table sweeper.
// Holds the vector geometry, the FSM state encoding and the mapping
// from a 5-bit vector index onto the {X,Y,Z,K,M} stimulus pins.
package barrido_tabla_verdad_pkg;

  localparam int NUM_VARS    = 5;
  localparam int NUM_VECTORS = 32;

  typedef logic [NUM_VARS-1:0] vec_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Bit position of each stimulus variable inside the vector index.
  // X is the MSB so that the truth-table bit order matches {X,Y,Z,K,M}.
  localparam int BIT_X = 4;
  localparam int BIT_Y = 3;
  localparam int BIT_Z = 2;
  localparam int BIT_K = 1;
  localparam int BIT_M = 0;

  // Returns the stimulus pins packed as {X,Y,Z,K,M}.
  function automatic logic [NUM_VARS-1:0] idx_to_xyzkm(input vec_idx_t idx);
    return {idx[BIT_X], idx[BIT_Y], idx[BIT_Z], idx[BIT_K], idx[BIT_M]};
  endfunction

endpackage

// File: rtl/barrido_tabla_verdad_if.sv
// Bus between the lab controller / function under test and the sweeper.
// master: controller side (start, abort, expected table) plus the F_in
//         return path from the function under test; reads all results.
// slave:  the sweeper itself; drives stimulus pins, status and results.
interface barrido_tabla_verdad_if;
  import barrido_tabla_verdad_pkg::*;

  logic                   start;
  logic                   abort;
  logic [NUM_VECTORS-1:0] exp_table;
  logic                   F_in;
  logic                   X;
  logic                   Y;
  logic                   Z;
  logic                   K;
  logic                   M;
  logic                   busy;
  logic                   done;
  logic                   table_valid;
  logic [NUM_VECTORS-1:0] truth_table;
  logic [5:0]             ones_cnt;
  logic                   mismatch;
  logic [NUM_VARS-1:0]    first_fail;

  modport master (
    output start, abort, exp_table, F_in,
    input  X, Y, Z, K, M, busy, done, table_valid,
           truth_table, ones_cnt, mismatch, first_fail
  );

  modport slave (
    input  start, abort, exp_table, F_in,
    output X, Y, Z, K, M, busy, done, table_valid,
           truth_table, ones_cnt, mismatch, first_fail
  );

endinterface

// File: rtl/barrido_tabla_verdad_settle_timer.sv
// Settle timer for the sweeper.
// Ports:
//   clk_i     - system clock, rising edge
//   rst_n_i   - asynchronous active-low reset
//   clear_i   - synchronous clear to zero (has priority over enable)
//   enable_i  - count up by one
//   expired_o - high while the count equals SETTLE-1
module tt_settle_timer #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is seen in the SETTLE-th DRIVE cycle, so the FSM leaves DRIVE
  // after exactly SETTLE cycles.
  assign expired_o = (count_q == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/barrido_tabla_verdad.sv
// Truth-table sweeper: drives {X,Y,Z,K,M} through all 32 vectors, holds
// each for SETTLE cycles, samples F_in, and builds the truth table,
// minterm count and a comparison against an expected table.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of barrido_tabla_verdad_if (start/abort/exp_table/F_in
//           in; stimulus pins, busy/done/table_valid and results out)
module barrido_tabla_verdad
  import barrido_tabla_verdad_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  barrido_tabla_verdad_if.slave bus
);

  state_e                 state_q;
  vec_idx_t               idx_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   table_valid_q;
  logic [NUM_VECTORS-1:0] truth_table_q;
  logic [5:0]             ones_cnt_q;
  logic                   mismatch_q;
  vec_idx_t               first_fail_q;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  // The counter only runs in DRIVE; every other state (and abort) parks it
  // at zero so each vector starts with a fresh settle window.
  assign timer_clear = (state_q != DRIVE) || bus.abort;
  assign timer_en    = (state_q == DRIVE);

  tt_settle_timer #(
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) u_settle_timer (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      table_valid_q <= 1'b0;
      truth_table_q <= '0;
      ones_cnt_q    <= '0;
      mismatch_q    <= 1'b0;
      first_fail_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort is ignored here, so start wins when both are high.
          if (bus.start) begin
            state_q       <= DRIVE;
            busy_q        <= 1'b1;
            idx_q         <= '0;
            table_valid_q <= 1'b0;
            truth_table_q <= '0;
            ones_cnt_q    <= '0;
            mismatch_q    <= 1'b0;
            first_fail_q  <= '0;
          end
        end

        DRIVE: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else if (timer_expired) begin
            state_q <= SAMPLE;
          end
        end

        SAMPLE: begin
          // An abort here drops the vector uncaptured; everything captured
          // so far stays visible.
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else begin
            truth_table_q[idx_q] <= bus.F_in;
            ones_cnt_q           <= ones_cnt_q + 6'(bus.F_in);
            // Only the first differing vector is recorded.
            if ((bus.F_in != bus.exp_table[idx_q]) && !mismatch_q) begin
              mismatch_q   <= 1'b1;
              first_fail_q <= idx_q;
            end
            if (idx_q == vec_idx_t'(NUM_VECTORS - 1)) begin
              state_q       <= DONE;
              done_q        <= 1'b1;
              table_valid_q <= 1'b1;
              busy_q        <= 1'b0;
              idx_q         <= '0;
            end else begin
              state_q <= DRIVE;
              idx_q   <= idx_q + 1'b1;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {bus.X, bus.Y, bus.Z, bus.K, bus.M} = idx_to_xyzkm(idx_q);
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.table_valid = table_valid_q;
  assign bus.truth_table = truth_table_q;
  assign bus.ones_cnt    = ones_cnt_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.first_fail  = first_fail_q;

endmodule

// File: tb/tb_barrido_tabla_verdad.sv
// Directed testbench for barrido_tabla_verdad. The function under test is
// modelled by funcSel: 0 -> F=X, 1 -> F=M, 2 -> F=0. Cycle numbering: the
// start pulse is sampled at edge 0, and cycle n is the period after edge n-1.
module tb_barrido_tabla_verdad;

  logic clk;
  logic rst_n;
  int   funcSel;
  int   errorCount;
  int   checkCount;
  int   doneCycle;
  int   sawDone;

  barrido_tabla_verdad_if tbIf ();

  barrido_tabla_verdad #(
    .SETTLE (2),
    .CNT_W  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under test selected by funcSel.
  always_comb begin
    tbIf.F_in = 1'b0;
    case (funcSel)
      0:       tbIf.F_in = tbIf.X;
      1:       tbIf.F_in = tbIf.M;
      default: tbIf.F_in = 1'b0;
    endcase
  end

  function automatic logic [4:0] getVec();
    return {tbIf.X, tbIf.Y, tbIf.Z, tbIf.K, tbIf.M};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string where);
    checkOutput({where, "_vec"},        32'(getVec()),                 32'd0);
    checkOutput({where, "_busy"},       32'(tbIf.busy),                32'd0);
    checkOutput({where, "_done"},       32'(tbIf.done),                32'd0);
    checkOutput({where, "_tableValid"}, 32'(tbIf.table_valid),         32'd0);
    checkOutput({where, "_truthTable"}, tbIf.truth_table,              32'd0);
    checkOutput({where, "_onesCnt"},    32'(tbIf.ones_cnt),            32'd0);
    checkOutput({where, "_mismatch"},   32'(tbIf.mismatch),            32'd0);
    checkOutput({where, "_firstFail"},  32'(tbIf.first_fail),          32'd0);
  endtask

  // Selects the function, loads the expected table and issues a start pulse
  // sampled at edge 0. Returns at edge 0 + #1.
  task automatic applyStimulus(input int sel, input logic [31:0] expTable);
    @(negedge clk);
    funcSel        = sel;
    tbIf.exp_table = expTable;
    tbIf.start     = 1'b1;
    @(posedge clk);
    #1;
    tbIf.start = 1'b0;
  endtask

  // Waits edges firstEdge..lastEdge for done; optionally checks that the
  // vector index equals edge/3 while the sweep is running.
  task automatic waitDone(input int firstEdge, input int lastEdge,
                          input bit checkVectors, output int cycleOfDone);
    cycleOfDone = 0;
    for (int n = firstEdge; n <= lastEdge; n++) begin
      @(posedge clk);
      #1;
      if (tbIf.done) begin
        cycleOfDone = n + 1;
        break;
      end
      if (checkVectors) begin
        checkOutput($sformatf("vecAtCycle%0d", n + 1), 32'(getVec()), 32'(n / 3));
      end
    end
    if (cycleOfDone == 0) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
    end
  endtask

  task automatic checkResults(input string where, input logic [31:0] expTruth,
                              input int expOnes, input logic expMis,
                              input int expFirst);
    checkOutput({where, "_doneCycle"},  32'(doneCycle),        32'd97);
    checkOutput({where, "_tableValid"}, 32'(tbIf.table_valid), 32'd1);
    checkOutput({where, "_busyInDone"}, 32'(tbIf.busy),        32'd0);
    checkOutput({where, "_vecInDone"},  32'(getVec()),         32'd0);
    checkOutput({where, "_truthTable"}, tbIf.truth_table,      expTruth);
    checkOutput({where, "_onesCnt"},    32'(tbIf.ones_cnt),    32'(expOnes));
    checkOutput({where, "_mismatch"},   32'(tbIf.mismatch),    32'(expMis));
    checkOutput({where, "_firstFail"},  32'(tbIf.first_fail),  32'(expFirst));
    @(posedge clk);
    #1;
    checkOutput({where, "_donePulseEnds"},   32'(tbIf.done),        32'd0);
    checkOutput({where, "_tableValidHolds"}, 32'(tbIf.table_valid), 32'd1);
  endtask

  initial begin
    errorCount     = 0;
    checkCount     = 0;
    funcSel        = 2;
    rst_n          = 1'b0;
    tbIf.start     = 1'b0;
    tbIf.abort     = 1'b0;
    tbIf.exp_table = '0;

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // F = X: upper half of the table is ones.
    $display("[TB] sweep F=X");
    applyStimulus(0, 32'hFFFF0000);
    checkOutput("x_busyAfterStart", 32'(tbIf.busy), 32'd1);
    waitDone(1, 150, 1'b0, doneCycle);
    checkResults("x", 32'hFFFF0000, 16, 1'b0, 0);

    // F = M with per-cycle vector tracking (each vector held 3 cycles).
    $display("[TB] sweep F=M");
    applyStimulus(1, 32'hAAAAAAAA);
    waitDone(1, 150, 1'b1, doneCycle);
    checkResults("m", 32'hAAAAAAAA, 16, 1'b0, 0);

    // F = 0 against a single expected minterm at vector 4.
    $display("[TB] sweep F=0");
    applyStimulus(2, 32'h00000010);
    waitDone(1, 150, 1'b0, doneCycle);
    checkResults("zero", 32'h00000000, 0, 1'b1, 4);

    // Abort sampled at edge 40: vectors 0..12 already captured with F=M.
    $display("[TB] abort mid-sweep");
    applyStimulus(1, 32'hAAAAAAAA);
    repeat (39) @(posedge clk);
    #1;
    tbIf.abort = 1'b1;
    @(posedge clk);
    #1;
    tbIf.abort = 1'b0;
    checkOutput("abort_busy",       32'(tbIf.busy),        32'd0);
    checkOutput("abort_vec",        32'(getVec()),         32'd0);
    checkOutput("abort_tableValid", 32'(tbIf.table_valid), 32'd0);
    checkOutput("abort_partial",    tbIf.truth_table,      32'h00000AAA);
    checkOutput("abort_onesCnt",    32'(tbIf.ones_cnt),    32'd6);
    sawDone = 0;
    for (int n = 0; n < 110; n++) begin
      @(posedge clk);
      #1;
      if (tbIf.done) sawDone = 1;
    end
    checkOutput("abort_noDone",     32'(sawDone),   32'd0);
    checkOutput("abort_busyStays0", 32'(tbIf.busy), 32'd0);

    // Restart after abort; expected table differs at vectors 6 and 22.
    $display("[TB] restart after abort");
    applyStimulus(0, 32'hFFBF0040);
    waitDone(1, 150, 1'b0, doneCycle);
    checkResults("restart", 32'hFFFF0000, 16, 1'b1, 6);

    // Second start during the sweep must not restart it.
    $display("[TB] start while busy");
    applyStimulus(0, 32'hFFFF0000);
    repeat (19) @(posedge clk);
    @(negedge clk);
    tbIf.start = 1'b1;
    @(posedge clk);
    #1;
    tbIf.start = 1'b0;
    waitDone(21, 150, 1'b0, doneCycle);
    checkResults("busyStart", 32'hFFFF0000, 16, 1'b0, 0);

    // Async reset in cycle 50 of a sweep.
    $display("[TB] reset mid-sweep");
    applyStimulus(0, 32'hFFFF0000);
    repeat (49) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midReset");
    @(negedge clk);
    rst_n = 1'b1;

    // start and abort together in IDLE: start wins; then abort it.
    $display("[TB] start and abort together");
    @(negedge clk);
    funcSel    = 0;
    tbIf.start = 1'b1;
    tbIf.abort = 1'b1;
    @(posedge clk);
    #1;
    tbIf.start = 1'b0;
    tbIf.abort = 1'b0;
    checkOutput("startWins_busy", 32'(tbIf.busy), 32'd1);
    @(negedge clk);
    tbIf.abort = 1'b1;
    @(posedge clk);
    #1;
    tbIf.abort = 1'b0;
    checkOutput("finalAbort_busy", 32'(tbIf.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
